// File: rtl/dcache_store_buffer_if.sv
// Store-buffer bus: memory-stage store/load side plus the two dcache write ports.
interface dcache_store_buffer_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [63:0]   st_addr;
  logic [63:0]   st_data;
  logic          drain_hold;
  logic [63:0]   ld_addr;
  logic          fwd_hit;
  logic [63:0]   fwd_data;
  logic [63:0]   cache_addr_high;
  logic [63:0]   cache_data_in_high;
  logic [63:0]   cache_addr_low;
  logic [63:0]   cache_data_in_low;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, drain_hold, ld_addr,
    input  st_ready, fwd_hit, fwd_data, cache_addr_high, cache_data_in_high,
           cache_addr_low, cache_data_in_low, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, drain_hold, ld_addr,
    output st_ready, fwd_hit, fwd_data, cache_addr_high, cache_data_in_high,
           cache_addr_low, cache_data_in_low, count, empty
  );
endinterface

// File: rtl/dcache_store_buffer.sv
// In-order store FIFO that retires up to two oldest entries per cycle onto the
// dcache H/L write ports and forwards the youngest matching store to loads.
module dcache_store_buffer #(
  parameter int          DEPTH       = 8,
  parameter logic [10:0] SCRATCH_IDX = 11'h7FF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dcache_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [10:0]   idx_q  [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_nx, slot;
  logic [CW-1:0] count_q, count_d;
  logic          enq;
  logic [1:0]    n;
  logic [10:0]   h_idx, l_idx;
  logic [63:0]   h_data, l_data;
  logic          hit;
  logic [63:0]   fwd;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.st_addr[63:11], bus.ld_addr[63:11]};

  always_comb begin
    enq = bus.st_valid && (count_q < CW'(DEPTH));
    if (bus.drain_hold || count_q == '0) n = 2'd0;
    else if (count_q == CW'(1))          n = 2'd1;
    else                                 n = 2'd2;
    head_nx = head_q + PW'(1);
    head_d  = head_q + PW'(n);
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(n);
  end

  // Idle ports write the reserved scratch index so the cache never sees a stale store.
  always_comb begin
    h_idx  = SCRATCH_IDX;
    h_data = '0;
    l_idx  = SCRATCH_IDX;
    l_data = '0;
    if (n != 2'd0) begin
      h_idx  = idx_q[head_q];
      h_data = data_q[head_q];
    end
    if (n == 2'd2) begin
      l_idx  = idx_q[head_nx];
      l_data = data_q[head_nx];
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit  = 1'b0;
    fwd  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && (idx_q[slot] == bus.ld_addr[10:0])) begin
        hit = 1'b1;
        fwd = data_q[slot];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      idx_q[tail_q]  <= bus.st_addr[10:0];
      data_q[tail_q] <= bus.st_data;
    end
  end

  assign bus.st_ready           = (count_q < CW'(DEPTH));
  assign bus.empty              = (count_q == '0);
  assign bus.count              = count_q;
  assign bus.fwd_hit            = hit;
  assign bus.fwd_data           = fwd;
  assign bus.cache_addr_high    = {53'd0, h_idx};
  assign bus.cache_data_in_high = h_data;
  assign bus.cache_addr_low     = {53'd0, l_idx};
  assign bus.cache_data_in_low  = l_data;
endmodule
